// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder tree.
// - add_mode_e : per-vector operand interpretation, carried through every stage
// - tree_lvls  : number of tree levels (= pipeline stages) for a given input count
// - lvl_cnt    : number of values held after a given level (level 0 = the inputs)
package adder_pkg;

    typedef enum logic {
        ADD_UNSIGNED = 1'b0,
        ADD_SIGNED   = 1'b1
    } add_mode_e;

    function automatic int tree_lvls(input int num);
        return $clog2(num);
    endfunction

    // Each level halves the value count, rounding up because an odd last
    // value passes through unpaired.
    function automatic int lvl_cnt(input int num, input int lvl);
        int n;
        n = num;
        for (int k = 0; k < lvl; k++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One level of the adder tree: pairwise add of N_IN values into ceil(N_IN/2)
// values one bit wider, then a register with valid bit and mode flag.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   src_data   N_IN values of IN_BITS each, value k at [k*IN_BITS +: IN_BITS]
//   src_vld    upstream holds a vector
//   src_mode   signedness of the upstream vector
//   down_en    downstream stage (or consumer) can take this stage's contents
//   en         this stage loads on the next edge
//   data       N_OUT registered values of OUT_BITS each
//   vld        registered valid
//   mode       registered signedness, travels with the vector
//
// Handshake: a stage loads whenever it is empty or its contents leave this
// cycle (en = ~vld | down_en); the upstream stage treats en as its ready,
// so an empty stage fills even while everything below it is stalled.
module adder_tree_stage
    import adder_pkg::*;
#(
    parameter int  IN_BITS  = 8,
    parameter int  N_IN     = 4,
    localparam int N_OUT    = (N_IN + 1) / 2,
    localparam int OUT_BITS = IN_BITS + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_IN*IN_BITS-1:0]   src_data,
    input  logic                      src_vld,
    input  add_mode_e                 src_mode,
    input  logic                      down_en,
    output logic                      en,
    output logic [N_OUT*OUT_BITS-1:0] data,
    output logic                      vld,
    output add_mode_e                 mode
);

    logic [N_OUT*OUT_BITS-1:0] sum;

    function automatic logic [OUT_BITS-1:0] ext(input logic [IN_BITS-1:0] x,
                                                input add_mode_e m);
        return {(m == ADD_SIGNED) ? x[IN_BITS-1] : 1'b0, x};
    endfunction

    // Both operands are extended by one bit first, so the OUT_BITS-wide sum
    // is exact for either interpretation.
    always_comb begin
        sum = '0;
        for (int j = 0; j < N_IN / 2; j++) begin
            sum[j*OUT_BITS +: OUT_BITS] =
                ext(src_data[(2*j)*IN_BITS +: IN_BITS], src_mode) +
                ext(src_data[(2*j+1)*IN_BITS +: IN_BITS], src_mode);
        end
        if (N_IN % 2 == 1) begin
            sum[(N_OUT-1)*OUT_BITS +: OUT_BITS] =
                ext(src_data[(N_IN-1)*IN_BITS +: IN_BITS], src_mode);
        end
    end

    assign en = ~vld | down_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= '0;
            mode <= ADD_UNSIGNED;
        end else begin
            if (en) begin
                vld <= src_vld;
            end
            // Payload only changes when a real vector arrives.
            if (en && src_vld) begin
                data <= sum;
                mode <= src_mode;
            end
        end
    end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined NUM-input adder tree with valid/ready flow control.
// One registered stage per tree level (LVLS = $clog2(NUM)), so an accepted
// vector appears at the output LVLS cycles later when not stalled.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   input vector valid
//   in_ready   vector accepted on this edge if in_valid is also high
//   in_signed  1: operands two's complement, 0: unsigned
//   i          NUM operands, lane k = i[k*BITS +: BITS]
//   out_valid  result valid
//   out_ready  consumer takes the result on this edge
//   o          sum, BITS+LVLS wide (exact) or BITS wide (SAT=1, clamped)
//   out_ovf    SAT=1: result was clamped; constant 0 otherwise
//
// Handshake: a transfer happens on an edge where valid and ready are both
// high; valid never waits for ready, and while out_valid is high and
// out_ready low, o/out_ovf/out_valid do not change.
module adder_tree_pipe
    import adder_pkg::*;
#(
    parameter int  BITS = 8,
    parameter int  NUM  = 4,
    parameter int  SAT  = 0,
    localparam int LVLS = tree_lvls(NUM),
    localparam int OW   = (SAT != 0) ? BITS : BITS + LVLS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic [NUM*BITS-1:0] i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OW-1:0]     o,
    output logic              out_ovf
);

    localparam int FW = BITS + LVLS;

    for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
        localparam int N_IN  = lvl_cnt(NUM, l - 1);
        localparam int N_OUT = lvl_cnt(NUM, l);
        localparam int IN_W  = BITS + l - 1;

        logic [N_IN*IN_W-1:0]      src_data;
        logic                      src_vld;
        add_mode_e                 src_mode;
        logic                      down_en;
        logic                      en;
        logic [N_OUT*(IN_W+1)-1:0] data;
        logic                      vld;
        add_mode_e                 mode;

        if (l == 1) begin : g_head
            assign src_data = i;
            assign src_vld  = in_valid;
            assign src_mode = add_mode_e'(in_signed);
        end else begin : g_body
            assign src_data = g_lvl[l-1].data;
            assign src_vld  = g_lvl[l-1].vld;
            assign src_mode = g_lvl[l-1].mode;
        end

        if (l == LVLS) begin : g_tail
            assign down_en = out_ready;
        end else begin : g_mid
            assign down_en = g_lvl[l+1].en;
        end

        adder_tree_stage #(
            .IN_BITS (IN_W),
            .N_IN    (N_IN)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .src_data (src_data),
            .src_vld  (src_vld),
            .src_mode (src_mode),
            .down_en  (down_en),
            .en       (en),
            .data     (data),
            .vld      (vld),
            .mode     (mode)
        );
    end

    logic [FW-1:0] fin;

    assign in_ready  = g_lvl[1].en;
    assign out_valid = g_lvl[LVLS].vld;
    assign fin       = g_lvl[LVLS].data;

    if (SAT != 0) begin : g_sat
        localparam logic signed [FW-1:0] SMAX = FW'((2 ** (BITS - 1)) - 1);
        localparam logic signed [FW-1:0] SMIN = ~SMAX;

        // The tree itself is exact; clamping is purely a view of the final
        // full-width value, so out_ovf is registered-data driven and stable.
        always_comb begin
            o       = fin[BITS-1:0];
            out_ovf = 1'b0;
            if (g_lvl[LVLS].mode == ADD_SIGNED) begin
                if ($signed(fin) > SMAX) begin
                    o       = {1'b0, {(BITS-1){1'b1}}};
                    out_ovf = 1'b1;
                end else if ($signed(fin) < SMIN) begin
                    o       = {1'b1, {(BITS-1){1'b0}}};
                    out_ovf = 1'b1;
                end
            end else if (fin[FW-1:BITS] != '0) begin
                o       = '1;
                out_ovf = 1'b1;
            end
        end
    end else begin : g_exact
        // Full-width result already carries the correct sign/zero extension.
        assign o       = fin;
        assign out_ovf = 1'b0;
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe. Three instances share the stimulus:
//   u_dut4 BITS=8 NUM=4 SAT=0 (10-bit exact), u_dut5 BITS=8 NUM=5 SAT=0
//   (11-bit exact, odd lane), u_sat BITS=8 NUM=4 SAT=1 (8-bit clamped).
// NUM=4 instances see the low 32 bits of the shared 40-bit vector.
module tb_adder_tree_pipe;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_signed = 1'b0;
    logic        out_ready = 1'b0;
    logic [39:0] vec       = '0;

    logic        rdy4, ov4, ovf4;
    logic [9:0]  o4;
    logic        rdy5, ov5, ovf5;
    logic [10:0] o5;
    logic        rdys, ovs, ovfs;
    logic [7:0]  os;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- DUTs ----------------
    adder_tree_pipe #(.BITS(8), .NUM(4), .SAT(0)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .in_signed(in_signed), .i(vec[31:0]), .out_valid(ov4),
        .out_ready(out_ready), .o(o4), .out_ovf(ovf4)
    );

    adder_tree_pipe #(.BITS(8), .NUM(5), .SAT(0)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy5),
        .in_signed(in_signed), .i(vec), .out_valid(ov5),
        .out_ready(out_ready), .o(o5), .out_ovf(ovf5)
    );

    adder_tree_pipe #(.BITS(8), .NUM(4), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdys),
        .in_signed(in_signed), .i(vec[31:0]), .out_valid(ovs),
        .out_ready(out_ready), .o(os), .out_ovf(ovfs)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Send one vector with out_ready=1 and measure per-instance latency and
    // captured result.
    task automatic run_vec(input string tag, input logic [39:0] v,
                           input logic sgn, input logic [9:0] e4,
                           input logic [10:0] e5, input logic [7:0] es,
                           input logic eovf);
        int lat4, lat5, lats;
        logic [9:0]  c4;
        logic [10:0] c5;
        logic [7:0]  cs;
        logic        cf, cf4, cf5;
        lat4 = 0; lat5 = 0; lats = 0;
        c4 = '0; c5 = '0; cs = '0; cf = 1'b0; cf4 = 1'b0; cf5 = 1'b0;
        @(negedge clk);
        vec       = v;
        in_signed = sgn;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(rdy4 & rdy5 & rdys), 32'd1);
        for (int lat = 1; lat <= 6; lat++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (ov4 && lat4 == 0) begin lat4 = lat; c4 = o4; cf4 = ovf4; end
            if (ov5 && lat5 == 0) begin lat5 = lat; c5 = o5; cf5 = ovf5; end
            if (ovs && lats == 0) begin lats = lat; cs = os; cf = ovfs; end
        end
        check({tag, "_lat4"}, 32'(lat4), 32'd2);
        check({tag, "_lat5"}, 32'(lat5), 32'd3);
        check({tag, "_lats"}, 32'(lats), 32'd2);
        check({tag, "_o4"},   32'(c4),   32'(e4));
        check({tag, "_o5"},   32'(c5),   32'(e5));
        check({tag, "_os"},   32'(cs),   32'(es));
        check({tag, "_ovfs"}, 32'(cf),   32'(eovf));
        check({tag, "_ovf45"}, 32'(cf4 | cf5), 32'd0);
    endtask

    // Stream 8 vectors (sums 0..7) into u_dut4 with out_ready 1,0,0,1,0,0...
    task automatic backpressure();
        int sent, got, occ, c;
        logic       held;
        logic [9:0] held_o;
        logic       acc, pop;
        sent = 0; got = 0; occ = 0; c = 0; held = 1'b0; held_o = '0;
        exp_q.delete();
        while (got < 8 && c < 80) begin
            @(negedge clk);
            out_ready = (c % 3 == 0);
            in_valid  = (sent < 8);
            in_signed = 1'b0;
            vec       = 40'(sent);
            #1;
            if (held) begin
                check("bp_hold_o", 32'(o4), 32'(held_o));
                check("bp_hold_v", 32'(ov4), 32'd1);
            end
            check("bp_inrdy", 32'(rdy4), 32'(out_ready || occ < 2));
            acc = in_valid && rdy4;
            pop = ov4 && out_ready;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra", 32'(o4), 32'hFFFF_FFFF);
                end else begin
                    check("bp_sum", 32'(o4), exp_q.pop_front());
                end
                got++;
            end
            held   = ov4 && !out_ready;
            held_o = o4;
            if (acc) begin
                exp_q.push_back(32'(sent));
                sent++;
            end
            occ = occ + int'(acc) - int'(pop);
            c++;
        end
        in_valid = 1'b0;
        check("bp_count", 32'(got), 32'd8);
        check("bp_left", 32'(exp_q.size()), 32'd0);
    endtask

    // One vector parked at the output with out_ready=0, then a second one
    // must still enter the empty first stage.
    task automatic bubble_collapse();
        @(negedge clk);
        out_ready = 1'b0;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        vec       = 40'd5;
        #1;
        check("bub_rdy1", 32'(rdy4), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("bub_v1", 32'(ov4), 32'd1);
        check("bub_o1", 32'(o4), 32'd5);
        in_valid = 1'b1;
        vec      = 40'd9;
        #1;
        check("bub_rdy2", 32'(rdy4), 32'd1);
        @(negedge clk);
        vec = 40'd77;
        #1;
        check("bub_full", 32'(rdy4), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("bub_hold", 32'(o4), 32'd5);
        out_ready = 1'b1;
        #1;
        check("bub_rdy3", 32'(rdy4), 32'd1);
        @(negedge clk);
        check("bub_o2v", 32'(ov4), 32'd1);
        check("bub_o2", 32'(o4), 32'd9);
        @(negedge clk);
        check("bub_drain", 32'(ov4), 32'd0);
    endtask

    task automatic reset_mid_flight();
        int stale;
        stale = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        vec       = 40'd3;
        @(negedge clk);
        vec = 40'd4;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rmf_v", 32'(ov4 | ov5 | ovs), 32'd0);
        check("rmf_o4", 32'(o4), 32'd0);
        check("rmf_o5", 32'(o5), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ov4 || ov5 || ovs) stale++;
        end
        check("rmf_stale", 32'(stale), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        do_reset();
        check("rst_v4", 32'(ov4), 32'd0);
        check("rst_o4", 32'(o4), 32'd0);
        check("rst_os", 32'(os), 32'd0);
        check("rst_ovf", 32'(ovf4 | ovf5 | ovfs), 32'd0);
        check("rst_rdy", 32'(rdy4 & rdy5 & rdys), 32'd1);

        run_vec("u255",  40'h00_FF_FF_FF_FF, 1'b0, 10'h3FC, 11'h3FC, 8'hFF, 1'b1);
        run_vec("sm128", 40'h80_80_80_80_80, 1'b1, 10'h200, 11'h580, 8'h80, 1'b1);
        run_vec("s300",  40'h00_64_64_64_00, 1'b1, 10'h12C, 11'h12C, 8'h7F, 1'b1);
        run_vec("u300",  40'h00_C8_64_00_00, 1'b0, 10'h12C, 11'h12C, 8'hFF, 1'b1);
        run_vec("u10",   40'h00_01_02_03_04, 1'b0, 10'h00A, 11'h00A, 8'h0A, 1'b0);
        run_vec("sodd",  40'hFF_00_00_00_00, 1'b1, 10'h000, 11'h7FF, 8'h00, 1'b0);
        run_vec("uodd",  40'hFF_00_00_00_00, 1'b0, 10'h000, 11'h0FF, 8'h00, 1'b0);
        run_vec("sm3",   40'h00_FB_02_00_00, 1'b1, 10'h3FD, 11'h7FD, 8'hFD, 1'b0);
        run_vec("sm256", 40'h00_80_80_00_00, 1'b1, 10'h300, 11'h700, 8'h80, 1'b1);
        run_vec("s127",  40'h00_00_00_00_7F, 1'b1, 10'h07F, 11'h07F, 8'h7F, 1'b0);

        do_reset();
        backpressure();
        do_reset();
        bubble_collapse();
        do_reset();
        reset_mid_flight();
        run_vec("post",  40'h00_01_02_03_04, 1'b0, 10'h00A, 11'h00A, 8'h0A, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
